// File: rtl/xdisp_scan.sv
// Multiplexed seven-segment scanner: frame-synchronous shadow->active update,
// per-digit decimal points, leading-zero suppression and per-slot blanking.

module xdisp_digit (
  input  logic [3:0] nib,
  output logic [6:0] seg,
  output logic       nz
);
  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  assign nz = |nib;
endmodule

module xdisp_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1024,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  data_we,
  input  logic                  blank_in,
  input  logic                  lz_suppress,
  output logic [7:0]            Disp,
  output logic [N_DIGITS-1:0]   Disp_sel,
  output logic                  frame_tick
);
  localparam int P_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int D_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [P_W-1:0] P_MAX = P_W'(REFRESH_DIV - 1);
  localparam logic [P_W-1:0] P_BLK = P_W'(BLANK_CYC);
  localparam logic [D_W-1:0] D_MAX = D_W'(N_DIGITS - 1);

  typedef struct packed {
    logic [N_DIGITS-1:0]      dp;
    logic [N_DIGITS-1:0][3:0] nib;
  } frame_t;

  logic [P_W-1:0] p;
  logic [D_W-1:0] d;
  frame_t         shadow, active, wr_val;
  logic           pending;
  logic           frame_end;

  assign wr_val    = {dp_in, data_in};
  assign frame_end = (p == P_MAX) && (d == D_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      d <= '0;
    end else if (p == P_MAX) begin
      p <= '0;
      d <= (d == D_MAX) ? '0 : d + 1'b1;
    end else begin
      p <= p + 1'b1;
    end
  end

  // A write landing on the frame-end edge bypasses the shadow so it is not held a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (data_we) begin
      shadow <= wr_val;
      if (frame_end) begin
        active  <= wr_val;
        pending <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (frame_end && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  logic [N_DIGITS-1:0][6:0] seg_all;
  logic [N_DIGITS-1:0]      nz;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_dig
      xdisp_digit u_dig (
        .nib (active.nib[gi]),
        .seg (seg_all[gi]),
        .nz  (nz[gi])
      );
    end
  endgenerate

  // Index of the most significant nonzero nibble; 0 when all zero keeps digit 0 lit.
  logic [D_W-1:0] hi;
  always_comb begin
    hi = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (nz[i]) hi = D_W'(i);
  end

  logic                in_blank, lz_hide;
  logic [N_DIGITS-1:0] sel_nxt;
  logic [7:0]          disp_nxt;

  always_comb begin
    in_blank = (p < P_BLK);
    lz_hide  = lz_suppress && (d > hi);
    sel_nxt  = in_blank ? '1 : ~(N_DIGITS'(1) << d);
    disp_nxt = 8'hFF;
    if (!in_blank && !blank_in) begin
      if (lz_hide) disp_nxt = {~active.dp[d], 7'h7F};
      else         disp_nxt = {~active.dp[d], seg_all[d]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Disp       <= 8'hFF;
      Disp_sel   <= '1;
      frame_tick <= 1'b0;
    end else begin
      Disp       <= disp_nxt;
      Disp_sel   <= sel_nxt;
      frame_tick <= frame_end;
    end
  end
endmodule
